// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - bus bundle between scanner, CPU port, RAM macro and the VRAM arbiter
//
// Groups the scanner port (video_*), the CPU port (cpu_*) and the RAM macro port (mem_*).
// The slave modport is the arbiter's view. The master modport is the view of the
// surrounding system: scanner, CPU and RAM.
interface vram_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          video_req;
    logic [AW-1:0] video_a;
    logic [DW-1:0] video_q;
    logic          video_miss;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_a;
    logic [DW-1:0] cpu_d;
    logic [DW-1:0] cpu_q;
    logic          cpu_ready;

    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    modport slave (
        input  video_req, video_a, cpu_req, cpu_we, cpu_a, cpu_d, mem_q,
        output video_q, video_miss, cpu_q, cpu_ready, mem_a, mem_d, mem_we
    );

    modport master (
        output video_req, video_a, cpu_req, cpu_we, cpu_a, cpu_d, mem_q,
        input  video_q, video_miss, cpu_q, cpu_ready, mem_a, mem_d, mem_we
    );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: scanner priority, CPU on free cycles with bounded-wait override
//
// Ports:
//   clock         system clock, all state on rising edge
//   reset_n       asynchronous active-low reset
//   bus.video_*   scanner address/request in, read data (mem_q passthrough) and miss pulse out
//   bus.cpu_*     CPU request/we/address/data in, registered read data and ready pulse out
//   bus.mem_*     RAM macro address/write data/write enable out, read data in
module vram_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    vram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t        state_q, state_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          cpu_ready_q, cpu_ready_d;
    logic [DW-1:0] cpu_q_q, cpu_q_d;
    logic          video_miss_q, video_miss_d;
    logic          we_q, we_d;
    logic          grant;
    logic [AW-1:0] mem_a_w;

    // reset_n gates the grant so that the RAM sees no write and the scanner address
    // while reset is held, even if the CPU is requesting.
    assign grant = reset_n && (state_q == IDLE) && bus.cpu_req &&
                   (!bus.video_req || (wait_cnt_q == MAX_WAIT_C));

    assign mem_a_w        = grant ? bus.cpu_a : bus.video_a;
    assign bus.mem_a      = mem_a_w;
    assign bus.mem_d      = bus.cpu_d;
    assign bus.mem_we     = grant && bus.cpu_we;
    assign bus.video_q    = bus.mem_q;
    assign bus.video_miss = video_miss_q;
    assign bus.cpu_q      = cpu_q_q;
    assign bus.cpu_ready  = cpu_ready_q;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        cpu_ready_d  = 1'b0;
        cpu_q_d      = cpu_q_q;
        video_miss_d = 1'b0;
        we_d         = we_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d      = DATA;
                    wait_cnt_d   = 8'd0;
                    we_d         = bus.cpu_we;
                    // A grant taken over an active video slot steals that slot.
                    video_miss_d = bus.video_req;
                end else if (!bus.cpu_req) begin
                    wait_cnt_d = 8'd0;
                end else if (bus.video_req && (wait_cnt_q != MAX_WAIT_C)) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            DATA: begin
                state_d     = ACK;
                cpu_ready_d = 1'b1;
                // mem_q now holds the data for the address presented in the grant cycle.
                if (!we_q) begin
                    cpu_q_d = bus.mem_q;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 8'd0;
            cpu_ready_q  <= 1'b0;
            cpu_q_q      <= '0;
            video_miss_q <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_q_q      <= cpu_q_d;
            video_miss_q <= video_miss_d;
            we_q         <= we_d;
        end
    end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port synchronous video RAM between the text-mode scanner (fixed, latency-critical fetch slots) and the CPU bus (request/ready handshake). The scanner owns the RAM in every cycle it asks for it. The CPU is granted any free cycle, with a bounded-wait override that guarantees forward progress. The block sits between the scanner's video_a/video_q pair, the CPU memory port and the RAM macro.

## Interface
- AW, 16, address width (RAM and both requesters)
- DW, 8, data width
- MAX_WAIT, 8, consecutive blocked cycles before the CPU overrides video; legal range 1..255

- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- video_req  in  1  scanner drives a valid video_a this cycle
- video_a  in  AW  scanner address
- video_q  out  DW  RAM read data to scanner (= mem_q, passthrough)
- video_miss  out  1  one-cycle pulse: a video slot was overridden
- cpu_req  in  1  CPU access request, level, held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_a  in  AW  CPU address; stable while cpu_req
- cpu_d  in  DW  CPU write data; stable while cpu_req
- cpu_q  out  DW  registered read data, valid while cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- mem_a  out  AW  RAM address (combinational mux)
- mem_d  out  DW  RAM write data
- mem_we  out  1  RAM write enable
- mem_q  in  DW  RAM read data, valid the cycle after its address

## Operation
- FSM states: IDLE, DATA, ACK.
- IDLE, grant condition: cpu_req && (!video_req || wait_cnt == MAX_WAIT). The grant cycle is G.
  - In G: mem_a = cpu_a, mem_d = cpu_d, mem_we = cpu_we. Next state DATA; wait_cnt cleared.
- IDLE, no grant:
  - mem_a = video_a, mem_we = 0.
  - If cpu_req && video_req: wait_cnt increments, saturating at MAX_WAIT.
  - If !cpu_req: wait_cnt clears.
- DATA (G+1): mem_a = video_a, mem_we = 0. Register cpu_q <= mem_q (reads only; writes leave cpu_q unchanged) and cpu_ready <= 1. Next state ACK.
- ACK (G+2): cpu_ready = 1. mem_a = video_a. Next state IDLE; cpu_ready <= 0.
- Override: if the grant was taken while video_req = 1, video_miss <= 1 for exactly cycle G+1. That slot's video data is undefined.
- mem_we is asserted only in a grant cycle with cpu_we = 1. It is never asserted in DATA, ACK or any video-owned cycle.
- When video_req = 0 and no grant is taken, mem_a = video_a anyway (harmless read).
- cpu_req dropped mid-wait: no grant is issued and wait_cnt clears. A drop after G has no effect; the access completes and cpu_ready still pulses.
- Width rules: wait_cnt is 8 bits, compared as unsigned against MAX_WAIT. Addresses and data pass through unmodified.

## Timing
- Reset (async, reset_n = 0): state IDLE, wait_cnt 0, cpu_ready 0, cpu_q 0, video_miss 0.
  - During reset, mem_we = 0 and mem_a = video_a.
  - A write whose grant cycle completed before reset is already in RAM. A read in DATA/ACK is aborted with no cpu_ready.
- CPU latency: G to cpu_ready is 2 cycles. For an uncontended request raised in cycle 0, cpu_ready is high in cycle 2.
- Minimum grant spacing is 3 cycles (G, DATA, ACK). A held cpu_req re-grants at G+3 at the earliest.
- Video latency: the address is presented in cycle N and mem_q/video_q are valid in cycle N+1, unaffected by CPU traffic except in override cycles.
- Worst-case CPU wait under continuous video_req is MAX_WAIT cycles before the grant.
- Simultaneous video_req and cpu_req with wait_cnt < MAX_WAIT: video wins.

## Test plan
- RAM[0x8000]=0x41, video_req=0, cpu read 0x8000 raised in cycle 0 -> mem_a=0x8000 in cycle 0; cpu_ready=1 only in cycle 2; cpu_q=0x41; video_miss stays 0.
- Collision: video_req=1 in cycles 0-1 (video_a=0x8010, RAM=0x55), cpu read from cycle 0 -> video_q=0x55 in cycle 1; grant in cycle 2; cpu_ready in cycle 4.
- Starvation: MAX_WAIT=8, video_req held 1, cpu write 0x9000<-0xA5 from cycle 0 -> mem_we=1 only in cycle 8; video_miss=1 only in cycle 9; cpu_ready in cycle 10; RAM[0x9000]=0xA5.
- Back-to-back: cpu_req held with no video -> grants in cycles 0, 3, 6; cpu_ready in cycles 2, 5, 8; write-then-read of 0x8002 returns the written value.
- Scanner pattern: video_req high 2 of every 8 cycles, random CPU traffic over 10k cycles -> video_miss never asserts; every video_q matches the RAM model; every request completes within 5 cycles.
- Reset in DATA of a read -> cpu_ready stays 0; state IDLE; a new request after release completes normally in 2 cycles.
